// File: rtl/layer_compositor.sv
// Layer compositor: priority-based sprite compositing with optional 50% blend,
// per-frame shadowed enable/blend masks and per-frame collision reporting.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_x, i_y, i_de      pixel coordinate and active-video qualifier
//   i_v_sync            frame sync (rising edge = frame boundary)
//   i_layer_hit         per-layer hit for the current pixel
//   i_layer_rgb         packed layer colours, layer k at [k*3*COLOR_W +: 3*COLOR_W]
//   i_bg_rgb            background colour (red in the MS field)
//   i_layer_en          requested layer enables (taken at frame boundary)
//   i_blend_en          requested blend enables (taken at frame boundary)
//   o_red/green/blue    composited pixel, two edges after the sampling edge
//   o_x, o_y, o_de      coordinate and qualifier aligned with the pixel
//   o_winner            winning layer index, NUM_LAYERS for background
//   o_collision         per-layer overlap flags of the previous frame
//   o_frame_done        one-cycle pulse after each frame boundary
module layer_compositor #(
    parameter int NUM_LAYERS = 8,
    parameter int COLOR_W    = 8,
    parameter int COORD_W    = 16,
    localparam int unsigned WIN_W = ($clog2(NUM_LAYERS + 1) < 1) ? 1 : $clog2(NUM_LAYERS + 1),
    localparam int unsigned PIX_W = 3 * COLOR_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [COORD_W-1:0]           i_x,
    input  logic [COORD_W-1:0]           i_y,
    input  logic                         i_de,
    input  logic                         i_v_sync,
    input  logic [NUM_LAYERS-1:0]        i_layer_hit,
    input  logic [NUM_LAYERS*PIX_W-1:0]  i_layer_rgb,
    input  logic [PIX_W-1:0]             i_bg_rgb,
    input  logic [NUM_LAYERS-1:0]        i_layer_en,
    input  logic [NUM_LAYERS-1:0]        i_blend_en,
    output logic [COLOR_W-1:0]           o_red,
    output logic [COLOR_W-1:0]           o_green,
    output logic [COLOR_W-1:0]           o_blue,
    output logic [COORD_W-1:0]           o_x,
    output logic [COORD_W-1:0]           o_y,
    output logic                         o_de,
    output logic [WIN_W-1:0]             o_winner,
    output logic [NUM_LAYERS-1:0]        o_collision,
    output logic                         o_frame_done
);

    // ---------------- frame control ----------------
    logic                  v_sync_q;
    logic                  frame_edge_c;
    logic [NUM_LAYERS-1:0] act_en_q, act_en_d;
    logic [NUM_LAYERS-1:0] act_blend_q, act_blend_d;
    logic [NUM_LAYERS-1:0] acc_q, acc_d;
    logic [NUM_LAYERS-1:0] coll_q, coll_d;
    logic                  done_q;
    logic [NUM_LAYERS-1:0] eff_c;
    logic                  multi_hit_c;

    assign frame_edge_c = i_v_sync & ~v_sync_q;

    // Effective hit and overlap detection (x & (x-1) != 0 means two or more bits set)
    always_comb begin
        eff_c       = i_de ? (i_layer_hit & act_en_q) : '0;
        multi_hit_c = (eff_c & (eff_c - NUM_LAYERS'(1))) != '0;
    end

    // Masks shadowed at frame boundary; edge-cycle collisions belong to the new frame
    always_comb begin
        act_en_d    = act_en_q;
        act_blend_d = act_blend_q;
        coll_d      = coll_q;
        acc_d       = acc_q;
        if (frame_edge_c) begin
            act_en_d    = i_layer_en;
            act_blend_d = i_blend_en;
            coll_d      = acc_q;
            acc_d       = '0;
        end
        if (multi_hit_c) begin
            acc_d = acc_d | eff_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v_sync_q    <= 1'b1;
            act_en_q    <= '1;
            act_blend_q <= '0;
            acc_q       <= '0;
            coll_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            v_sync_q    <= i_v_sync;
            act_en_q    <= act_en_d;
            act_blend_q <= act_blend_d;
            acc_q       <= acc_d;
            coll_q      <= coll_d;
            done_q      <= frame_edge_c;
        end
    end

    // ---------------- stage 1: capture qualified pixel ----------------
    logic                        s1_de_q;
    logic [COORD_W-1:0]          s1_x_q, s1_y_q;
    logic [NUM_LAYERS-1:0]       s1_eff_q;
    logic [NUM_LAYERS-1:0]       s1_blend_q;
    logic [NUM_LAYERS*PIX_W-1:0] s1_rgb_q;
    logic [PIX_W-1:0]            s1_bg_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_de_q    <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_eff_q   <= '0;
            s1_blend_q <= '0;
            s1_rgb_q   <= '0;
            s1_bg_q    <= '0;
        end else begin
            s1_de_q    <= i_de;
            s1_x_q     <= i_x;
            s1_y_q     <= i_y;
            s1_eff_q   <= eff_c;
            s1_blend_q <= act_blend_q;
            s1_rgb_q   <= i_layer_rgb;
            s1_bg_q    <= i_bg_rgb;
        end
    end

    // ---------------- stage 2: winner / under selection ----------------
    logic [WIN_W-1:0] win_d, s2_win_q;
    logic [PIX_W-1:0] wcol_d, s2_wcol_q;
    logic [PIX_W-1:0] ucol_d, s2_ucol_q;
    logic             wblend_d, s2_blend_q;
    logic             s2_de_q;
    logic [COORD_W-1:0] s2_x_q, s2_y_q;

    // Scan from lowest priority upward: each hit demotes the previous winner to "under"
    always_comb begin
        win_d    = WIN_W'(NUM_LAYERS);
        wcol_d   = s1_bg_q;
        ucol_d   = s1_bg_q;
        wblend_d = 1'b0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (s1_eff_q[k]) begin
                ucol_d   = wcol_d;
                wcol_d   = s1_rgb_q[k*PIX_W +: PIX_W];
                wblend_d = s1_blend_q[k];
                win_d    = WIN_W'(k);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_de_q    <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_win_q   <= '0;
            s2_wcol_q  <= '0;
            s2_ucol_q  <= '0;
            s2_blend_q <= 1'b0;
        end else begin
            s2_de_q    <= s1_de_q;
            s2_x_q     <= s1_x_q;
            s2_y_q     <= s1_y_q;
            s2_win_q   <= win_d;
            s2_wcol_q  <= wcol_d;
            s2_ucol_q  <= ucol_d;
            s2_blend_q <= wblend_d;
        end
    end

    // ---------------- stage 3: blend and output gating ----------------
    logic [PIX_W-1:0] out_rgb_q, out_rgb_d;
    logic [WIN_W-1:0] out_win_q, out_win_d;
    logic [COORD_W-1:0] out_x_q, out_y_q;
    logic             out_de_q;
    logic [PIX_W-1:0] mix_c;
    logic [COLOR_W:0] sum_c;

    // Per-channel average at COLOR_W+1 bits so the carry is kept before the halving
    always_comb begin
        mix_c = '0;
        sum_c = '0;
        for (int c = 0; c < 3; c++) begin
            sum_c = {1'b0, s2_wcol_q[c*COLOR_W +: COLOR_W]}
                  + {1'b0, s2_ucol_q[c*COLOR_W +: COLOR_W]};
            mix_c[c*COLOR_W +: COLOR_W] = sum_c[COLOR_W:1];
        end
    end

    always_comb begin
        out_rgb_d = s2_blend_q ? mix_c : s2_wcol_q;
        out_win_d = s2_win_q;
        if (!s2_de_q) begin
            out_rgb_d = '0;
            out_win_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_rgb_q <= '0;
            out_win_q <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_de_q  <= 1'b0;
        end else begin
            out_rgb_q <= out_rgb_d;
            out_win_q <= out_win_d;
            out_x_q   <= s2_x_q;
            out_y_q   <= s2_y_q;
            out_de_q  <= s2_de_q;
        end
    end

    assign o_red        = out_rgb_q[2*COLOR_W +: COLOR_W];
    assign o_green      = out_rgb_q[COLOR_W +: COLOR_W];
    assign o_blue       = out_rgb_q[0 +: COLOR_W];
    assign o_x          = out_x_q;
    assign o_y          = out_y_q;
    assign o_de         = out_de_q;
    assign o_winner     = out_win_q;
    assign o_collision  = coll_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed self-checking bench for layer_compositor (4 layers, 8-bit colour).
module tb_layer_compositor;

    logic        clk;
    logic        rst;
    logic [15:0] x, y;
    logic        de;
    logic        v_sync;
    logic [3:0]  hit;
    logic [95:0] lrgb;
    logic [23:0] bg;
    logic [3:0]  len, ben;
    logic [7:0]  red, green, blue;
    logic [15:0] ox, oy;
    logic        ode;
    logic [2:0]  win;
    logic [3:0]  coll;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    layer_compositor #(.NUM_LAYERS(4), .COLOR_W(8), .COORD_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_de(de), .i_v_sync(v_sync),
        .i_layer_hit(hit), .i_layer_rgb(lrgb), .i_bg_rgb(bg),
        .i_layer_en(len), .i_blend_en(ben),
        .o_red(red), .o_green(green), .o_blue(blue), .o_x(ox), .o_y(oy), .o_de(ode),
        .o_winner(win), .o_collision(coll), .o_frame_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One pixel for one cycle, then idle; returns on the negedge after its output edge
    task automatic drive_pixel(input logic [3:0] h, input logic [95:0] l, input logic [23:0] b,
                               input logic [15:0] px, input logic [15:0] py, input logic d);
        @(negedge clk);
        hit = h; lrgb = l; bg = b; x = px; y = py; de = d;
        @(negedge clk);
        hit = '0; de = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // v_sync rising edge; checks reported collisions and the one-cycle done pulse
    task automatic frame_edge(input logic [3:0] exp_coll, input string tag);
        @(negedge clk);
        de = 1'b0; hit = '0; v_sync = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b expected 1", tag, done); end
        n_cmp++;
        if (coll !== exp_coll) begin n_err++; $display("FAIL %s_coll: got %b expected %b", tag, coll, exp_coll); end
        v_sync = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_end: got %b expected 0", tag, done); end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({red, green, blue, win, ode, coll, done} !== 33'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {red, green, blue, win, ode, coll, done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_priority;
        @(negedge clk);
        hit = 4'b0110; lrgb = {24'h0, 24'hC8C8C8, 24'h0A141E, 24'h0}; bg = 24'h010101;
        x = 16'd7; y = 16'd9; de = 1'b1;
        @(negedge clk);
        hit = '0; de = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ode !== 1'b0) begin n_err++; $display("FAIL prio_early: got o_de=%b expected 0", ode); end
        @(negedge clk);
        n_cmp++;
        if ({red, green, blue} !== 24'h0A141E) begin n_err++; $display("FAIL prio_rgb: got %h expected 0a141e", {red, green, blue}); end
        n_cmp++;
        if ({win, ode, ox, oy} !== {3'd1, 1'b1, 16'd7, 16'd9}) begin
            n_err++; $display("FAIL prio_meta: got win=%0d de=%b x=%0d y=%0d expected 1 1 7 9", win, ode, ox, oy);
        end
    endtask

    task automatic test_de_gate;
        drive_pixel(4'b1111, {4{24'hFFFFFF}}, 24'h123456, 16'd123, 16'd45, 1'b0);
        n_cmp++;
        if ({red, green, blue, win, ode} !== 28'd0) begin
            n_err++; $display("FAIL de_gate_pix: got rgb=%h win=%0d de=%b expected 0", {red, green, blue}, win, ode);
        end
        n_cmp++;
        if ({ox, oy} !== {16'd123, 16'd45}) begin n_err++; $display("FAIL de_gate_xy: got %0d,%0d expected 123,45", ox, oy); end
    endtask

    task automatic test_blend;
        ben = 4'b0001;
        frame_edge(4'b0110, "edge1");
        ben = 4'b0000;
        drive_pixel(4'b0011, {24'h0, 24'h0, 24'h333200, 24'h6432FF}, 24'h0, 16'd1, 16'd1, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h4B327F, 3'd0}) begin
            n_err++; $display("FAIL blend_layers: got %h win=%0d expected 4b327f win=0", {red, green, blue}, win);
        end
        drive_pixel(4'b0001, {24'h0, 24'h0, 24'h0, 24'h0A0A0A}, 24'h00000A, 16'd2, 16'd1, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h05050A, 3'd0}) begin
            n_err++; $display("FAIL blend_bg: got %h win=%0d expected 05050a win=0", {red, green, blue}, win);
        end
        drive_pixel(4'b0000, {4{24'hAAAAAA}}, 24'h00000A, 16'd3, 16'd1, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h00000A, 3'd4}) begin
            n_err++; $display("FAIL bg_only: got %h win=%0d expected 00000a win=4", {red, green, blue}, win);
        end
        frame_edge(4'b0011, "edge2");
    endtask

    task automatic test_shadowing;
        len = 4'b1110;
        drive_pixel(4'b0011, {24'h0, 24'h0, 24'h040506, 24'h010203}, 24'h090909, 16'd4, 16'd2, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h010203, 3'd0}) begin
            n_err++; $display("FAIL shadow_mid: got %h win=%0d expected 010203 win=0", {red, green, blue}, win);
        end
        frame_edge(4'b0011, "edge3");
        drive_pixel(4'b0011, {24'h0, 24'h0, 24'h040506, 24'h010203}, 24'h090909, 16'd5, 16'd2, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h040506, 3'd1}) begin
            n_err++; $display("FAIL shadow_l1: got %h win=%0d expected 040506 win=1", {red, green, blue}, win);
        end
        drive_pixel(4'b0001, {24'h0, 24'h0, 24'h040506, 24'h010203}, 24'h090909, 16'd6, 16'd2, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h090909, 3'd4}) begin
            n_err++; $display("FAIL shadow_bg: got %h win=%0d expected 090909 win=4", {red, green, blue}, win);
        end
        len = 4'b1111;
        frame_edge(4'b0000, "edge4");
    endtask

    task automatic test_collision;
        int pulses;
        drive_pixel(4'b1010, {4{24'h111111}}, 24'h0, 16'd8, 16'd3, 1'b1);
        frame_edge(4'b1010, "coll_frame");
        frame_edge(4'b0000, "coll_clear");
        // overlap sampled on the edge cycle itself goes to the new frame
        @(negedge clk);
        v_sync = 1'b1; de = 1'b1; hit = 4'b1100;
        @(negedge clk);
        de = 1'b0; hit = '0; v_sync = 1'b0;
        n_cmp++;
        if ({done, coll} !== {1'b1, 4'b0000}) begin
            n_err++; $display("FAIL edge_pixel_old: got done=%b coll=%b expected 1 0000", done, coll);
        end
        frame_edge(4'b1100, "edge_pixel_new");
        // held-high v_sync yields a single pulse
        pulses = 0;
        @(negedge clk);
        v_sync = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        v_sync = 1'b0;
        n_cmp++;
        if (pulses !== 1) begin n_err++; $display("FAIL vsync_held: got %0d pulses expected 1", pulses); end
    endtask

    task automatic test_mid_reset;
        int pulses;
        drive_pixel(4'b1010, {4{24'h222222}}, 24'h0, 16'd9, 16'd4, 1'b1);
        len = 4'b1110;
        frame_edge(4'b1010, "pre_reset");
        drive_pixel(4'b0110, {24'h0, 24'h303030, 24'h070809, 24'h0}, 24'h0, 16'd10, 16'd4, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h070809, 3'd1}) begin
            n_err++; $display("FAIL pre_reset_pix: got %h win=%0d expected 070809 win=1", {red, green, blue}, win);
        end
        #1 rst = 1'b1; v_sync = 1'b1;
        #1;
        n_cmp++;
        if ({red, green, blue, win, ode, coll, done} !== 33'd0) begin
            n_err++; $display("FAIL async_reset: got %h expected 0", {red, green, blue, win, ode, coll, done});
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        v_sync = 1'b0;
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL release_vsync_high: got %0d pulses expected 0", pulses); end
        drive_pixel(4'b0001, {24'h0, 24'h0, 24'h0, 24'h0B0C0D}, 24'h000001, 16'd11, 16'd5, 1'b1);
        n_cmp++;
        if ({red, green, blue, win} !== {24'h0B0C0D, 3'd0}) begin
            n_err++; $display("FAIL reset_act_en: got %h win=%0d expected 0b0c0d win=0", {red, green, blue}, win);
        end
        len = 4'b1111;
        frame_edge(4'b0000, "post_reset");
    endtask

    initial begin
        rst = 1'b0; x = '0; y = '0; de = 1'b0; v_sync = 1'b0; hit = '0;
        lrgb = '0; bg = '0; len = 4'b1111; ben = 4'b0000;
        test_reset();
        test_priority();
        test_de_gate();
        test_blend();
        test_shadowing();
        test_collision();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
